// File: rtl/trigger_sequencer.sv
// trigger_sequencer: arms on request, waits for a synchronized rising edge on
// trig_in, then runs delay -> pulse -> holdoff and repeats cfg_repeat times
// (0 = until abort). Every accepted edge latches the free-running timebase.
//
// Build option: define TRIG_MISS_CNT_EN to enable the missed-edge counter
// (edges seen while DELAY/PULSE/HOLDOFF, saturating, cleared on arm). When
// undefined, miss_cnt is tied to 0 and the counter is not built.
module trigger_sequencer #(
  parameter int CNT_WIDTH = 24,
  parameter int DLY_WIDTH = 16,
  parameter int WID_WIDTH = 8,
  parameter int REP_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 arm,
  input  logic                 abort,
  input  logic                 trig_in,
  input  logic [DLY_WIDTH-1:0] cfg_delay,
  input  logic [WID_WIDTH-1:0] cfg_width,
  input  logic [DLY_WIDTH-1:0] cfg_holdoff,
  input  logic [REP_WIDTH-1:0] cfg_repeat,
  output logic                 trig_out,
  output logic                 armed,
  output logic                 busy,
  output logic                 done,
  output logic [REP_WIDTH-1:0] fire_cnt,
  output logic [CNT_WIDTH-1:0] ts_out,
  output logic                 ts_valid,
  output logic [7:0]           miss_cnt
);

  // One down-counter serves delay, pulse width and holdoff phases.
  localparam int CW = (DLY_WIDTH > WID_WIDTH) ? DLY_WIDTH : WID_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_DELAY,
    S_PULSE,
    S_HOLDOFF
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [REP_WIDTH-1:0] fire_q, fire_d;
  logic [CNT_WIDTH-1:0] timebase_q;
  logic [CNT_WIDTH-1:0] ts_q, ts_d;
  logic                 ts_valid_q, ts_valid_d;
  logic                 done_q, done_d;
  logic                 trig_q;
  logic                 load_cfg;
  logic                 shot_end;

  // Shadow configuration, frozen for the whole run.
  logic [DLY_WIDTH-1:0] dly_q, hold_q;
  logic [WID_WIDTH-1:0] wid_q;
  logic [REP_WIDTH-1:0] rep_q;

  // Synchronizer chain and edge detect.
  logic sync1_q, sync2_q, sync3_q;
  logic trig_edge;

  logic [CW-1:0] dly_m1, hold_m1, wid_m1;

  assign trig_edge = sync2_q & ~sync3_q;
  assign dly_m1    = CW'(dly_q) - CW'(1);
  assign hold_m1   = CW'(hold_q) - CW'(1);
  // A programmed width of 0 still produces a single-cycle pulse.
  assign wid_m1    = (wid_q == '0) ? '0 : CW'(wid_q) - CW'(1);

  // Free-running timebase, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timebase_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      timebase_q <= timebase_q + CNT_WIDTH'(1);
    end
  end

  // Two-flop synchronizer plus a third stage for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= trig_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // Next-state, counter, fire count and timestamp logic.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    fire_d     = fire_q;
    ts_d       = ts_q;
    ts_valid_d = 1'b0;
    done_d     = 1'b0;
    load_cfg   = 1'b0;
    shot_end   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d  = S_ARMED;
          fire_d   = '0;
          load_cfg = 1'b1;
        end
      end
      S_ARMED: begin
        if (trig_edge) begin
          ts_d       = timebase_q;
          ts_valid_d = 1'b1;
          if (dly_q != '0) begin
            state_d = S_DELAY;
            cnt_d   = dly_m1;
          end else begin
            state_d = S_PULSE;
            cnt_d   = wid_m1;
          end
        end
      end
      S_DELAY: begin
        if (cnt_q == '0) begin
          state_d = S_PULSE;
          cnt_d   = wid_m1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_PULSE: begin
        if (cnt_q == '0) begin
          fire_d = fire_q + REP_WIDTH'(1);
          if (hold_q != '0) begin
            state_d = S_HOLDOFF;
            cnt_d   = hold_m1;
          end else begin
            shot_end = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_HOLDOFF: begin
        if (cnt_q == '0) begin
          shot_end = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // fire_d already includes the shot that just finished.
    if (shot_end) begin
      if ((rep_q != '0) && (fire_d == rep_q)) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end else begin
        state_d = S_ARMED;
      end
    end

    // Abort wins over everything; counts and timestamp hold.
    if (abort) begin
      state_d    = S_IDLE;
      cnt_d      = cnt_q;
      fire_d     = fire_q;
      ts_d       = ts_q;
      ts_valid_d = 1'b0;
      done_d     = 1'b0;
      load_cfg   = 1'b0;
    end
  end

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      fire_q     <= '0;
      ts_q       <= '0;
      ts_valid_q <= 1'b0;
      done_q     <= 1'b0;
      trig_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fire_q     <= fire_d;
      ts_q       <= ts_d;
      ts_valid_q <= ts_valid_d;
      done_q     <= done_d;
      trig_q     <= (state_d == S_PULSE);
    end
  end

  // Capture configuration when a run is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_q  <= '0;
      wid_q  <= '0;
      hold_q <= '0;
      rep_q  <= '0;
    end else if (load_cfg) begin
      dly_q  <= cfg_delay;
      wid_q  <= cfg_width;
      hold_q <= cfg_holdoff;
      rep_q  <= cfg_repeat;
    end
  end

`ifdef TRIG_MISS_CNT_EN
  logic [7:0] miss_q, miss_d;
  logic       in_shot;

  assign in_shot = (state_q == S_DELAY) || (state_q == S_PULSE) ||
                   (state_q == S_HOLDOFF);

  // Missed-edge counter: clear on arm accept, saturate at 255.
  always_comb begin
    miss_d = miss_q;
    if (load_cfg) begin
      miss_d = '0;
    end else if (trig_edge && in_shot && (miss_q != 8'hFF)) begin
      miss_d = miss_q + 8'd1;
    end
  end

  // Missed-edge counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_q <= '0;
    end else begin
      miss_q <= miss_d;
    end
  end

  assign miss_cnt = miss_q;
`else
  assign miss_cnt = 8'd0;
`endif

  assign trig_out = trig_q;
  assign armed    = (state_q == S_ARMED);
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign fire_cnt = fire_q;
  assign ts_out   = ts_q;
  assign ts_valid = ts_valid_q;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Directed self-checking bench for trigger_sequencer. Inputs change and
// outputs are sampled 1 ns after each rising clock edge.
module tb_trigger_sequencer;

`ifdef TRIG_MISS_CNT_EN
  localparam int EXP_MISS = 4;
`else
  localparam int EXP_MISS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  logic        trig_in = 1'b0;
  logic [15:0] cfg_delay = '0;
  logic [7:0]  cfg_width = '0;
  logic [15:0] cfg_holdoff = '0;
  logic [7:0]  cfg_repeat = '0;
  logic        trig_out, armed, busy, done, ts_valid;
  logic [7:0]  fire_cnt, miss_cnt;
  logic [23:0] ts_out;

  int          total = 0;
  int          bad = 0;
  int          cyc;
  logic [23:0] exp_ts;
  int          pulses;
  int          done_seen;

  trigger_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .arm        (arm),
    .abort      (abort),
    .trig_in    (trig_in),
    .cfg_delay  (cfg_delay),
    .cfg_width  (cfg_width),
    .cfg_holdoff(cfg_holdoff),
    .cfg_repeat (cfg_repeat),
    .trig_out   (trig_out),
    .armed      (armed),
    .busy       (busy),
    .done       (done),
    .fire_cnt   (fire_cnt),
    .ts_out     (ts_out),
    .ts_valid   (ts_valid),
    .miss_cnt   (miss_cnt)
  );

  always #5 clk = ~clk;

  // Reference timebase: clock edges seen since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_arm(input logic [15:0] d, input logic [7:0] w,
                        input logic [15:0] h, input logic [7:0] r);
    cfg_delay   = d;
    cfg_width   = w;
    cfg_holdoff = h;
    cfg_repeat  = r;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  // One-cycle trig_in pulse; returns just after its sampling edge E0.
  task automatic trig_pulse();
    trig_in = 1'b1;
    tick();
    trig_in = 1'b0;
  endtask

  initial begin
    // Reset state
    #3;
    check("rst_trig_out", trig_out, 0);
    check("rst_busy", busy, 0);
    check("rst_armed", armed, 0);
    check("rst_done", done, 0);
    check("rst_fire_cnt", fire_cnt, 0);
    check("rst_ts_out", ts_out, 0);
    check("rst_ts_valid", ts_valid, 0);
    check("rst_miss_cnt", miss_cnt, 0);
    #9 rst_n = 1'b1;

    // 1: delay 0, width 1, repeat 1
    do_arm(16'd0, 8'd1, 16'd0, 8'd1);
    check("t1_armed", armed, 1);
    check("t1_busy", busy, 1);
    check("t1_fire0", fire_cnt, 0);
    trig_pulse();
    tick();
    check("t1_e1_low", trig_out, 0);
    exp_ts = cyc[23:0];
    tick();
    check("t1_e2_high", trig_out, 1);
    check("t1_ts_valid", ts_valid, 1);
    check("t1_ts_out", ts_out, exp_ts);
    tick();
    check("t1_e3_low", trig_out, 0);
    check("t1_done", done, 1);
    check("t1_busy_off", busy, 0);
    check("t1_fire1", fire_cnt, 1);
    check("t1_ts_valid_off", ts_valid, 0);
    tick();
    check("t1_done_off", done, 0);

    // 2: delay 5, width 3, holdoff 4, repeat 2; cfg change mid-run ignored
    do_arm(16'd5, 8'd3, 16'd4, 8'd2);
    cfg_delay = 16'd0; cfg_width = 8'd1; cfg_holdoff = 16'd0;
    for (int s = 1; s <= 2; s++) begin
      trig_pulse();
      tick(6);
      check("t2_e6_low", trig_out, 0);
      tick();
      check("t2_e7_high", trig_out, 1);
      tick();
      check("t2_e8_high", trig_out, 1);
      tick();
      check("t2_e9_high", trig_out, 1);
      tick();
      check("t2_e10_low", trig_out, 0);
      check("t2_fire", fire_cnt, s);
      tick(3);
      check("t2_hold_armed", armed, 0);
      check("t2_hold_done", done, 0);
      tick();
      if (s == 1) begin
        check("t2_rearmed", armed, 1);
      end else begin
        check("t2_done", done, 1);
        check("t2_busy_off", busy, 0);
      end
    end
    tick();
    check("t2_single_done", done, 0);

    // 3: edges during pulse/holdoff, including the last holdoff cycle
    do_arm(16'd0, 8'd1, 16'd10, 8'd1);
    check("t3_miss_clear", miss_cnt, 0);
    trig_pulse();
    tick(2);
    check("t3_pulse", trig_out, 1);
    for (int i = 2; i <= 12; i++) begin
      trig_in = (i == 2 || i == 4 || i == 6 || i == 10);
      tick();
      check("t3_no_pulse", trig_out, 0);
    end
    trig_in = 1'b0;
    check("t3_done", done, 1);
    check("t3_miss_cnt", miss_cnt, EXP_MISS);
    check("t3_fire", fire_cnt, 1);

    // 4: continuous mode, 10 shots, then abort mid-DELAY
    do_arm(16'd2, 8'd1, 16'd0, 8'd0);
    check("t4_miss_cleared", miss_cnt, 0);
    pulses = 0;
    done_seen = 0;
    repeat (10) begin
      trig_pulse();
      repeat (5) begin
        tick();
        if (trig_out) pulses++;
        if (done) done_seen++;
      end
    end
    check("t4_pulses", pulses, 10);
    check("t4_fire", fire_cnt, 10);
    check("t4_no_done", done_seen, 0);
    check("t4_still_armed", armed, 1);
    trig_pulse();
    tick(2);
    check("t4_in_delay", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_abort_idle", busy, 0);
    check("t4_abort_trig", trig_out, 0);
    check("t4_abort_done", done, 0);
    check("t4_abort_fire", fire_cnt, 10);
    repeat (3) begin
      tick();
      check("t4_post_abort_trig", trig_out, 0);
    end

    // 5: timestamps around timebase wrap
    do_arm(16'd0, 8'd1, 16'd0, 8'd2);
    trig_pulse();
    tick();
    force dut.timebase_q = 24'hFFFFFF;
    tick();
    check("t5_ts_ff", ts_out, 24'hFFFFFF);
    check("t5_valid1", ts_valid, 1);
    trig_in = 1'b1;
    tick();
    trig_in = 1'b0;
    check("t5_valid_gap1", ts_valid, 0);
    tick();
    check("t5_valid_gap2", ts_valid, 0);
    force dut.timebase_q = 24'h000002;
    tick();
    check("t5_ts_02", ts_out, 24'h000002);
    check("t5_valid2", ts_valid, 1);
    release dut.timebase_q;
    tick();
    check("t5_valid_off", ts_valid, 0);
    check("t5_done", done, 1);
    check("t5_fire", fire_cnt, 2);

    // 6a: arm and abort together stay IDLE
    arm = 1'b1;
    abort = 1'b1;
    tick();
    arm = 1'b0;
    abort = 1'b0;
    check("t6_arm_abort_busy", busy, 0);
    check("t6_arm_abort_armed", armed, 0);

    // 6b: width 0 gives a single-cycle pulse
    do_arm(16'd0, 8'd0, 16'd0, 8'd1);
    trig_pulse();
    tick(2);
    check("t6_w0_high", trig_out, 1);
    tick();
    check("t6_w0_low", trig_out, 0);
    check("t6_w0_done", done, 1);

    // 6c: asynchronous reset in the middle of a pulse
    do_arm(16'd0, 8'd5, 16'd0, 8'd1);
    trig_pulse();
    tick(2);
    check("t6_w5_high", trig_out, 1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_trig", trig_out, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_armed", armed, 0);
    check("t6_rst_fire", fire_cnt, 0);
    check("t6_rst_ts", ts_out, 0);
    check("t6_rst_ts_valid", ts_valid, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_miss", miss_cnt, 0);
    rst_n = 1'b1;
    tick();
    check("t6_post_rst_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
